// File: rtl/canny_frame_ctrl.sv
// Frame sequencer for the Canny back end: pixel coordinates, border flag,
// frame-aligned threshold updates and sticky geometry error flags.
module canny_frame_ctrl #(
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480,
  parameter int unsigned COL_W       = 10,
  parameter int unsigned ROW_W       = 10,
  parameter int unsigned TH_WIDTH    = 10,
  parameter int unsigned TH_HIGH_DEF = 100,
  parameter int unsigned TH_LOW_DEF  = 40
) (
  input  logic                clk,
  input  logic                rst_s,
  input  logic                in_vsync,
  input  logic                in_href,
  input  logic                in_clken,
  input  logic                cfg_req,
  input  logic [TH_WIDTH-1:0] cfg_high_th,
  input  logic [TH_WIDTH-1:0] cfg_low_th,
  output logic                cfg_ready,
  output logic                cfg_ack,
  output logic                cfg_nack,
  output logic [TH_WIDTH-1:0] th_high,
  output logic [TH_WIDTH-1:0] th_low,
  output logic                out_vsync,
  output logic                out_href,
  output logic                out_clken,
  output logic [COL_W-1:0]    out_col,
  output logic [ROW_W-1:0]    out_row,
  output logic                out_border,
  output logic                frame_done,
  output logic                err_line_len,
  output logic                err_frame_len,
  input  logic                err_clr,
  output logic [1:0]          state
);

  localparam logic [COL_W-1:0]    ColMax    = COL_W'(IMG_WIDTH);
  localparam logic [COL_W-1:0]    ColLast   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]    RowMax    = ROW_W'(IMG_HEIGHT);
  localparam logic [ROW_W-1:0]    RowLast   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [TH_WIDTH-1:0] ThHighDef = TH_WIDTH'(TH_HIGH_DEF);
  localparam logic [TH_WIDTH-1:0] ThLowDef  = TH_WIDTH'(TH_LOW_DEF);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitLine = 2'd1,
    StLine     = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                vsync_q, href_q, clken_q, sync_ok_q;
  logic [COL_W-1:0]    col_q, col_d, out_col_q, out_col_d, pix_col;
  logic [ROW_W-1:0]    row_q, row_d, out_row_q, out_row_d;
  logic                border_q, border_d;
  logic                pending_q, pending_d;
  logic [TH_WIDTH-1:0] sh_high_q, sh_high_d, sh_low_q, sh_low_d;
  logic [TH_WIDTH-1:0] th_high_q, th_high_d, th_low_q, th_low_d;
  logic                ack_q, ack_d, nack_q, nack_d, done_q, done_d;
  logic                err_line_q, err_line_d, err_frame_q, err_frame_d;
  logic                line_set, frame_set, pix;
  logic                vs_rise, vs_fall, hr_rise, hr_fall;

  // sync_ok_q blocks a false vsync rise when reset releases mid-frame.
  assign vs_rise = in_vsync & ~vsync_q & sync_ok_q;
  assign vs_fall = ~in_vsync & vsync_q;
  assign hr_rise = in_href & ~href_q;
  assign hr_fall = ~in_href & href_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    border_d    = border_q;
    pending_d   = pending_q;
    sh_high_d   = sh_high_q;
    sh_low_d    = sh_low_q;
    th_high_d   = th_high_q;
    th_low_d    = th_low_q;
    ack_d       = 1'b0;
    nack_d      = 1'b0;
    done_d      = 1'b0;
    line_set    = 1'b0;
    frame_set   = 1'b0;
    pix         = 1'b0;
    pix_col     = col_q;

    unique case (state_q)
      StIdle: begin
        if (vs_rise) begin
          state_d = StWaitLine;
          col_d   = '0;
          row_d   = '0;
          if (pending_q) begin
            th_high_d = sh_high_q;
            th_low_d  = sh_low_q;
            ack_d     = 1'b1;
            pending_d = 1'b0;
          end
        end
      end
      StWaitLine: begin
        if (vs_fall) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          frame_set = (row_q != RowMax);
        end else if (hr_rise) begin
          state_d = StLine;
          col_d   = '0;
          if (in_clken) begin
            pix     = 1'b1;
            pix_col = '0;
            col_d   = COL_W'(1);
          end
        end
      end
      StLine: begin
        if (vs_fall) begin
          state_d   = StIdle;
          line_set  = 1'b1;
          frame_set = 1'b1;
          done_d    = 1'b1;
        end else if (hr_fall) begin
          state_d  = StWaitLine;
          line_set = (col_q != ColMax);
          if (row_q != RowMax) row_d = row_q + ROW_W'(1);
        end else if (in_clken) begin
          pix = 1'b1;
          if (col_q != ColMax) col_d = col_q + COL_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (pix) begin
      out_col_d = pix_col;
      out_row_d = row_q;
      border_d  = (pix_col == '0) || (pix_col >= ColLast) ||
                  (row_q == '0) || (row_q >= RowLast);
    end

    // Acceptance needs pending_q low, so it never collides with the apply above.
    if (cfg_req && !pending_q) begin
      if (cfg_low_th <= cfg_high_th) begin
        sh_high_d = cfg_high_th;
        sh_low_d  = cfg_low_th;
        pending_d = 1'b1;
      end else begin
        nack_d = 1'b1;
      end
    end

    err_line_d  = line_set | (err_line_q & ~err_clr);
    err_frame_d = frame_set | (err_frame_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      state_q     <= StIdle;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      clken_q     <= 1'b0;
      sync_ok_q   <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      border_q    <= 1'b0;
      pending_q   <= 1'b0;
      sh_high_q   <= ThHighDef;
      sh_low_q    <= ThLowDef;
      th_high_q   <= ThHighDef;
      th_low_q    <= ThLowDef;
      ack_q       <= 1'b0;
      nack_q      <= 1'b0;
      done_q      <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= in_vsync;
      href_q      <= in_href;
      clken_q     <= in_clken;
      sync_ok_q   <= sync_ok_q | ~in_vsync;
      col_q       <= col_d;
      row_q       <= row_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      border_q    <= border_d;
      pending_q   <= pending_d;
      sh_high_q   <= sh_high_d;
      sh_low_q    <= sh_low_d;
      th_high_q   <= th_high_d;
      th_low_q    <= th_low_d;
      ack_q       <= ack_d;
      nack_q      <= nack_d;
      done_q      <= done_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
    end
  end

  assign cfg_ready     = ~pending_q;
  assign cfg_ack       = ack_q;
  assign cfg_nack      = nack_q;
  assign th_high       = th_high_q;
  assign th_low        = th_low_q;
  assign out_vsync     = vsync_q;
  assign out_href      = href_q;
  assign out_clken     = clken_q;
  assign out_col       = out_col_q;
  assign out_row       = out_row_q;
  assign out_border    = border_q;
  assign frame_done    = done_q;
  assign err_line_len  = err_line_q;
  assign err_frame_len = err_frame_q;
  assign state         = state_q;

endmodule

// File: doc/canny_frame_ctrl.md
Name: canny_frame_ctrl

Overview:
- Frame-level sequencer and configuration controller for the Canny back end, after non-maximum suppression and before hysteresis thresholding.
- Tracks the vsync/href/clken pixel stream and produces per-pixel column/row coordinates plus a border flag, so hysteresis can discard invalid 3x3 edge pixels.
- Owns the high/low threshold registers, accepts updates through a req/ack handshake, and applies them only at frame start.
- Checks line and frame geometry and raises sticky error flags.

Parameters:
IMG_WIDTH, 640, active pixels per line
IMG_HEIGHT, 480, active lines per frame
COL_W, 10, column counter width (must hold IMG_WIDTH)
ROW_W, 10, row counter width (must hold IMG_HEIGHT)
TH_WIDTH, 10, threshold width (matches gradient magnitude width)
TH_HIGH_DEF, 100, active high threshold after reset
TH_LOW_DEF, 40, active low threshold after reset

Ports:
clk  in  1  clock
rst_s  in  1  asynchronous active-low reset
in_vsync  in  1  frame valid, active high
in_href  in  1  line valid, active high
in_clken  in  1  pixel strobe; counted only while in_href=1
cfg_req  in  1  threshold update request
cfg_high_th  in  TH_WIDTH  requested high threshold
cfg_low_th  in  TH_WIDTH  requested low threshold
cfg_ready  out  1  1 = no update pending; a request can be accepted
cfg_ack  out  1  1-cycle pulse when the pending update becomes active
cfg_nack  out  1  1-cycle pulse when a request is rejected
th_high  out  TH_WIDTH  active high threshold
th_low  out  TH_WIDTH  active low threshold
out_vsync  out  1  in_vsync delayed 1 cycle
out_href  out  1  in_href delayed 1 cycle
out_clken  out  1  in_clken delayed 1 cycle
out_col  out  COL_W  column of the pixel marked by out_clken
out_row  out  ROW_W  row of the pixel marked by out_clken
out_border  out  1  1 = pixel is on the frame border
frame_done  out  1  1-cycle pulse at frame end
err_line_len  out  1  sticky line-length error
err_frame_len  out  1  sticky frame-length error
err_clr  in  1  synchronous clear of both sticky errors
state  out  2  current FSM state (debug)

Behaviour:
- Reset values: thresholds = TH_HIGH_DEF/TH_LOW_DEF; cfg_ready=1; all other outputs 0; FSM in IDLE; no update pending.
- Edge detection uses 1-cycle registered copies of in_vsync and in_href. Rise = current 1 and previous 0; fall = current 0 and previous 1.
- FSM states: IDLE=0, WAIT_LINE=1, LINE=2.
  - IDLE -> WAIT_LINE on vsync rise. row_cnt and col_cnt clear. A pending update is applied: active thresholds <= shadow, cfg_ack pulses, pending clears.
  - WAIT_LINE -> LINE on href rise. col_cnt clears.
  - LINE, each in_clken=1 cycle: the pixel takes coordinates (col_cnt, row_cnt), then col_cnt increments, saturating at IMG_WIDTH.
  - LINE -> WAIT_LINE on href fall. err_line_len sets if col_cnt != IMG_WIDTH. row_cnt increments, saturating at IMG_HEIGHT.
  - WAIT_LINE -> IDLE on vsync fall. frame_done pulses. err_frame_len sets if row_cnt != IMG_HEIGHT.
  - LINE -> IDLE on vsync fall (aborted line). err_line_len and err_frame_len both set; frame_done pulses.
  - Stream activity in IDLE (href/clken with vsync low) is ignored; no counting, no coordinates.
- Latency: out_* are the inputs delayed exactly 1 cycle. out_col/out_row/out_border are valid when out_clken=1; otherwise they hold their last value.
- out_border = 1 when col==0, col>=IMG_WIDTH-1, row==0, or row>=IMG_HEIGHT-1. Pixels beyond IMG_WIDTH are reported with col=IMG_WIDTH and out_border=1.
- Config handshake:
  - A request is accepted when cfg_req=1 and cfg_ready=1.
  - If cfg_low_th <= cfg_high_th, both values are captured into the shadow, pending is set, and cfg_ready falls on the next cycle.
  - Otherwise the request is rejected: cfg_nack pulses and state is unchanged.
  - cfg_req while pending is ignored (no ack, no nack); the requester holds it.
  - A request accepted in the same cycle as a vsync rise is NOT applied to that frame; it applies at the next vsync rise.
  - Active thresholds never change between vsync rise and vsync fall.
- Sticky errors: err_clr clears both. If err_clr and a set condition occur in the same cycle, set wins.
- Asynchronous reset mid-frame: everything returns to reset values and any pending update is discarded. The FSM resynchronises only on the next vsync rise; a frame already in progress is not counted.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=4; nominal frame of 4 lines x 8 clken with gaps -> out_col 0..7 per line, out_row 0..3; out_border=1 for row 0, row 3, col 0, col 7 only; one frame_done; no errors; out_* exactly 1 cycle behind inputs.
- cfg_req with high=200/low=50 mid-frame -> cfg_ready=0 next cycle; th_high/th_low stay 100/40 until the next vsync rise; cfg_ack pulses on that cycle with 200/50 active; cfg_ready returns to 1.
- cfg_req with high=30/low=60 -> cfg_nack pulse; thresholds and cfg_ready unchanged. A second cfg_req while pending -> no ack/nack, shadow unchanged.
- Line of 7 pixels, then a frame of 3 lines -> err_line_len=1 after that href fall; err_frame_len=1 at vsync fall; both stay 1 until err_clr; err_clr coinciding with a new error leaves the flag at 1.
- vsync falls while href=1 after 5 pixels of row 2 -> FSM returns to IDLE, both errors set, frame_done pulses; the next frame counts from (0,0) normally.
- rst_s asserted mid-line with an update pending -> all outputs at reset values; pending discarded (no ack at the next vsync); th_high=100, th_low=40.
